float_multiplier: RTL and testbench

//  IEEE-754 binary32 multiplier in the ADS1292 filter datapath. Multiplies a filter sample by a coefficient.

---
 rtl/float_multiplier_pkg.sv | 37 +++
 rtl/float_multiplier.sv | 192 +++++++++++++++++++
 tb/tb_float_multiplier.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/float_multiplier_pkg.sv
// Shared constants, state encoding and exponent helper for the binary32 multiplier.
// Consumed by float_multiplier; see that file for the FLOAT_MUL_FTZ_EN build option.
package float_multiplier_pkg;

    typedef enum logic [3:0] {
        ST_GET_A,
        ST_GET_B,
        ST_UNPACK,
        ST_SPECIAL,
        ST_NORM_A,
        ST_NORM_B,
        ST_MUL_0,
        ST_MUL_1,
        ST_NORM_1,
        ST_NORM_2,
        ST_ROUND,
        ST_PACK,
        ST_PUT_Z
    } state_t;

    localparam logic signed [9:0] EXP_BIAS  = 10'sd127;
    localparam logic signed [9:0] E_MIN     = -10'sd126;
    localparam logic signed [9:0] E_MAX     = 10'sd127;
    localparam logic signed [9:0] E_SPECIAL = 10'sd128;

    localparam logic [31:0] INF          = 32'h7F80_0000;
    localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;

    // Exponent field 0 encodes denormals, which share the minimum normal exponent.
    function automatic logic signed [9:0] unpack_exp(input logic [7:0] field);
        if (field == 8'd0) begin
            return E_MIN;
        end
        return $signed({2'b00, field}) - EXP_BIAS;
    endfunction

endpackage

// File: rtl/float_multiplier.sv
// IEEE-754 binary32 multiplier, one operation in flight, STB/ACK handshake on every port.
// Define FLOAT_MUL_FTZ_EN to flush denormal inputs and results to signed zero.
module float_multiplier
    import float_multiplier_pkg::*;
#(
    parameter logic [31:0] P_QNAN = QNAN_DEFAULT
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [31:0] i_A,
    input  logic        i_A_STB,
    output logic        o_A_ACK,
    input  logic [31:0] i_B,
    input  logic        i_B_STB,
    output logic        o_B_ACK,
    output logic [31:0] o_Z,
    output logic        o_Z_STB,
    input  logic        i_Z_ACK
);

    state_t             state_q;
    logic [31:0]        a_q, b_q, z_q;
    logic [23:0]        a_m_q, b_m_q, z_m_q;
    logic signed [9:0]  a_e_q, b_e_q, z_e_q;
    logic               a_s_q, b_s_q, z_s_q;
    logic               guard_q, round_q, sticky_q;
    logic [47:0]        prod_q;

    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]        prod_d;
    logic [24:0]        z_m_rnd_d;
    logic signed [9:0]  z_e_biased_d;

    assign a_nan = (a_e_q == E_SPECIAL) && (a_m_q[22:0] != 23'd0);
    assign b_nan = (b_e_q == E_SPECIAL) && (b_m_q[22:0] != 23'd0);
    assign a_inf = (a_e_q == E_SPECIAL) && (a_m_q[22:0] == 23'd0);
    assign b_inf = (b_e_q == E_SPECIAL) && (b_m_q[22:0] == 23'd0);
`ifdef FLOAT_MUL_FTZ_EN
    // A clear hidden bit means exponent field 0, so denormals count as zero here.
    assign a_zero = !a_m_q[23];
    assign b_zero = !b_m_q[23];
`else
    assign a_zero = (a_m_q == 24'd0);
    assign b_zero = (b_m_q == 24'd0);
`endif

    assign prod_d       = {24'd0, a_m_q} * {24'd0, b_m_q};
    assign z_m_rnd_d    = {1'b0, z_m_q} + 25'd1;
    assign z_e_biased_d = z_e_q + EXP_BIAS;

    // NOTE: only the handshake outputs and state are reset; datapath registers are
    // always written before use, so leaving them unreset keeps the reset fan-out small.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= ST_GET_A;
            o_A_ACK <= 1'b0;
            o_B_ACK <= 1'b0;
            o_Z_STB <= 1'b0;
            o_Z     <= 32'd0;
        end else begin
            case (state_q)
                ST_GET_A: begin
                    o_A_ACK <= 1'b1;
                    if (o_A_ACK && i_A_STB) begin
                        a_q     <= i_A;
                        o_A_ACK <= 1'b0;
                        state_q <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    o_B_ACK <= 1'b1;
                    if (o_B_ACK && i_B_STB) begin
                        b_q     <= i_B;
                        o_B_ACK <= 1'b0;
                        state_q <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    a_m_q   <= {|a_q[30:23], a_q[22:0]};
                    b_m_q   <= {|b_q[30:23], b_q[22:0]};
                    a_e_q   <= unpack_exp(a_q[30:23]);
                    b_e_q   <= unpack_exp(b_q[30:23]);
                    a_s_q   <= a_q[31];
                    b_s_q   <= b_q[31];
                    state_q <= ST_SPECIAL;
                end
                ST_SPECIAL: begin
                    z_s_q   <= a_s_q ^ b_s_q;
                    state_q <= ST_PUT_Z;
                    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                        z_q <= P_QNAN;
                    end else if (a_inf || b_inf) begin
                        z_q <= {a_s_q ^ b_s_q, INF[30:0]};
                    end else if (a_zero || b_zero) begin
                        z_q <= {a_s_q ^ b_s_q, 31'd0};
                    end else begin
`ifdef FLOAT_MUL_FTZ_EN
                        state_q <= ST_MUL_0;
`else
                        state_q <= ST_NORM_A;
`endif
                    end
                end
                ST_NORM_A: begin
                    if (a_m_q[23]) begin
                        state_q <= ST_NORM_B;
                    end else begin
                        a_m_q <= {a_m_q[22:0], 1'b0};
                        a_e_q <= a_e_q - 10'sd1;
                    end
                end
                ST_NORM_B: begin
                    if (b_m_q[23]) begin
                        state_q <= ST_MUL_0;
                    end else begin
                        b_m_q <= {b_m_q[22:0], 1'b0};
                        b_e_q <= b_e_q - 10'sd1;
                    end
                end
                ST_MUL_0: begin
                    prod_q  <= prod_d;
                    z_e_q   <= a_e_q + b_e_q + 10'sd1;
                    state_q <= ST_MUL_1;
                end
                ST_MUL_1: begin
                    z_m_q    <= prod_q[47:24];
                    guard_q  <= prod_q[23];
                    round_q  <= prod_q[22];
                    sticky_q <= |prod_q[21:0];
                    state_q  <= ST_NORM_1;
                end
                ST_NORM_1: begin
                    if (!z_m_q[23] && (z_e_q > E_MIN)) begin
                        z_m_q   <= {z_m_q[22:0], guard_q};
                        guard_q <= round_q;
                        round_q <= 1'b0;
                        z_e_q   <= z_e_q - 10'sd1;
                    end else begin
                        state_q <= ST_NORM_2;
                    end
                end
                ST_NORM_2: begin
                    // Underflow: shift toward the denormal range, folding lost bits into sticky.
                    if (z_e_q < E_MIN) begin
                        z_m_q    <= {1'b0, z_m_q[23:1]};
                        guard_q  <= z_m_q[0];
                        round_q  <= guard_q;
                        sticky_q <= sticky_q | round_q;
                        z_e_q    <= z_e_q + 10'sd1;
                    end else begin
                        state_q <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
                        z_m_q <= z_m_rnd_d[23:0];
                        if (z_m_rnd_d[24]) begin
                            z_e_q <= z_e_q + 10'sd1;
                        end
                    end
                    state_q <= ST_PACK;
                end
                ST_PACK: begin
                    state_q <= ST_PUT_Z;
                    if (z_e_q > E_MAX) begin
                        z_q <= {z_s_q, INF[30:0]};
                    end else if ((z_e_q == E_MIN) && !z_m_q[23]) begin
`ifdef FLOAT_MUL_FTZ_EN
                        z_q <= {z_s_q, 31'd0};
`else
                        z_q <= {z_s_q, 8'd0, z_m_q[22:0]};
`endif
                    end else begin
                        z_q <= {z_s_q, z_e_biased_d[7:0], z_m_q[22:0]};
                    end
                end
                ST_PUT_Z: begin
                    o_Z_STB <= 1'b1;
                    o_Z     <= z_q;
                    if (o_Z_STB && i_Z_ACK) begin
                        o_Z_STB <= 1'b0;
                        state_q <= ST_GET_A;
                    end
                end
                default: begin
                    state_q <= ST_GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_multiplier.sv
// Directed self-checking bench for float_multiplier: values, latency, handshake, reset.
// Expected values follow the FLOAT_MUL_FTZ_EN setting of the build.
module tb_float_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        a_stb, b_stb, z_ack;
    logic        a_ack, b_ack, z_stb;
    logic [31:0] z;

    int checks   = 0;
    int failures = 0;
    int ack_overlap = 0;

`ifdef FLOAT_MUL_FTZ_EN
    localparam int NORM_LAT = 9;
    localparam logic [31:0] DENORM_IN_Z  = 32'h0000_0000;
    localparam logic [31:0] DENORM_OUT_Z = 32'h0000_0000;
`else
    localparam int NORM_LAT = 11;
    localparam logic [31:0] DENORM_IN_Z  = 32'h0080_0000;
    localparam logic [31:0] DENORM_OUT_Z = 32'h0040_0000;
`endif
    localparam int SPECIAL_LAT = 3;

    float_multiplier dut (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_A     (a),
        .i_A_STB (a_stb),
        .o_A_ACK (a_ack),
        .i_B     (b),
        .i_B_STB (b_stb),
        .o_B_ACK (b_ack),
        .o_Z     (z),
        .o_Z_STB (z_stb),
        .i_Z_ACK (z_ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_ack && b_ack) ack_overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] v);
        int n = 0;
        a = v;
        a_stb = 1'b1;
        while (!a_ack && n < 50) begin
            tick();
            n++;
        end
        check("a_ack_arrives", {31'd0, a_ack}, 32'd1);
        tick();
        a_stb = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] v);
        int n = 0;
        b = v;
        b_stb = 1'b1;
        while (!b_ack && n < 50) begin
            tick();
            n++;
        end
        check("b_ack_arrives", {31'd0, b_ack}, 32'd1);
        tick();
        b_stb = 1'b0;
    endtask

    // Called just after the B transfer edge; returns edges until o_Z_STB is seen.
    task automatic wait_z(output int lat);
        lat = 0;
        while (!z_stb && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] exp_z, input int exp_lat);
        int lat;
        send_a(va);
        send_b(vb);
        wait_z(lat);
        check({tag, "_stb"}, {31'd0, z_stb}, 32'd1);
        if (exp_lat > 0) check({tag, "_lat"}, lat, exp_lat);
        check(tag, z, exp_z);
        z_ack = 1'b1;
        tick();
        z_ack = 1'b0;
    endtask

    initial begin
        int lat;
        int b_early, stb_low, z_changed, a_ack_seen, stb_seen;
        logic [31:0] z_hold;

        rst = 1'b1;
        a = '0; b = '0;
        a_stb = 1'b0; b_stb = 1'b0; z_ack = 1'b0;
        repeat (3) tick();
        check("rst_a_ack", {31'd0, a_ack}, 32'd0);
        check("rst_b_ack", {31'd0, b_ack}, 32'd0);
        check("rst_z_stb", {31'd0, z_stb}, 32'd0);
        check("rst_z", z, 32'd0);

        // B offered first must not be acknowledged before A is captured.
        b = 32'h4000_0000;
        b_stb = 1'b1;
        rst = 1'b0;
        b_early = 0;
        repeat (6) begin
            tick();
            if (b_ack) b_early++;
        end
        b_stb = 1'b0;
        check("b_before_a", b_early, 0);

        run_op("mul_1p5_2p0",   32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 0);
        run_op("mul_1p5_1p5",   32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, NORM_LAT);
        run_op("mul_sign",      32'hC020_0000, 32'h4080_0000, 32'hC120_0000, 0);
        run_op("mul_round_up",  32'h3FC0_0001, 32'h3FC0_0000, 32'h4010_0001, NORM_LAT);
        run_op("mul_round_dn",  32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, NORM_LAT);
        run_op("inf_x_zero",    32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, SPECIAL_LAT);
        run_op("zero_x_neginf", 32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, SPECIAL_LAT);
        run_op("nan_x_one",     32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, SPECIAL_LAT);
        run_op("inf_x_neg2",    32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, SPECIAL_LAT);
        run_op("negzero_x_one", 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, SPECIAL_LAT);
        run_op("overflow",      32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 0);
        run_op("denorm_in",     32'h0000_0001, 32'h4B00_0000, DENORM_IN_Z, 0);
        run_op("denorm_out",    32'h0080_0000, 32'h3F00_0000, DENORM_OUT_Z, 0);

        // Backpressure: result held, no new A accepted while it waits.
        send_a(32'h3F80_0000);
        send_b(32'h4000_0000);
        wait_z(lat);
        check("bp_stb", {31'd0, z_stb}, 32'd1);
        z_hold = z;
        a = 32'h4040_0000;
        a_stb = 1'b1;
        stb_low = 0; z_changed = 0; a_ack_seen = 0;
        repeat (20) begin
            tick();
            if (!z_stb) stb_low++;
            if (z !== z_hold) z_changed++;
            if (a_ack) a_ack_seen++;
        end
        check("bp_stb_held", stb_low, 0);
        check("bp_z_stable", z_changed, 0);
        check("bp_no_a_ack", a_ack_seen, 0);
        check("bp_value", z, 32'h4000_0000);
        z_ack = 1'b1;
        tick();
        z_ack = 1'b0;
        check("bp_stb_drop", {31'd0, z_stb}, 32'd0);
        check("bp_a_ack_late", {31'd0, a_ack}, 32'd0);
        tick();
        check("bp_a_ack_back", {31'd0, a_ack}, 32'd1);
        a_stb = 1'b0;

        // Reset pulse while the operation sits in MUL_1 (5 edges after B transfer).
        send_a(32'h3FC0_0000);
        send_b(32'h3FC0_0000);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("mrst_a_ack", {31'd0, a_ack}, 32'd0);
        check("mrst_b_ack", {31'd0, b_ack}, 32'd0);
        check("mrst_z_stb", {31'd0, z_stb}, 32'd0);
        check("mrst_z", z, 32'd0);
        rst = 1'b0;
        stb_seen = 0;
        repeat (20) begin
            tick();
            if (z_stb) stb_seen++;
        end
        check("mrst_no_result", stb_seen, 0);
        run_op("after_rst", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0);

        check("ab_ack_overlap", ack_overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
